// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch front end: streams sequential words from a variable-latency
// instruction memory into a small in-order buffer and serves the word matching core_pc.
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_pc,
    input  logic        core_halt,
    output logic [31:0] inst_data,
    output logic        inst_valid,
    output logic        misalign_err,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_CREDIT = DEPTH[CW:0];
    localparam logic [CW-1:0] DEPTH_CNT    = DEPTH[CW-1:0];
    localparam logic [31:0]   NOP          = 32'h0000_0013;

    logic [31:0]   stream_addr;
    logic [31:0]   fetch_addr;
    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic          redirect;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW:0]   credit_used;
    logic [CW-1:0] outstanding_after_resp;

    assign misalign_err = core_pc[1:0] != 2'b00;
    assign redirect     = (core_pc != stream_addr) && !misalign_err;
    assign empty        = count == '0;

    // Buffered words plus in-flight requests never exceed DEPTH, so a push always has room.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = !rst && !redirect && !misalign_err && (credit_used < DEPTH_CREDIT);
    assign imem_addr   = fetch_addr;
    assign accept      = imem_req && imem_gnt;

    // A response with nothing outstanding is ignored so the counter cannot underflow.
    assign resp                   = imem_rvalid && (outstanding != '0);
    assign outstanding_after_resp = outstanding - {{(CW-1){1'b0}}, resp};
    assign push                   = resp && !redirect && (discard == '0);

    assign inst_valid = !empty && (core_pc == stream_addr) && !misalign_err;
    assign inst_data  = inst_valid ? fifo_mem[rd_ptr] : NOP;
    assign pop        = inst_valid && !core_halt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stream_addr <= RESET_PC;
            fetch_addr  <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_after_resp + {{(CW-1){1'b0}}, accept};
            if (redirect) begin
                // Everything still in flight belongs to the old stream and must be dropped.
                stream_addr <= core_pc;
                fetch_addr  <= core_pc;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                discard     <= outstanding_after_resp;
            end else begin
                if (accept) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr      <= rd_ptr + 1'b1;
                    stream_addr <= stream_addr + 32'd4;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            if (push) begin
                assert (count != DEPTH_CNT || pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: a sequential-core driver, an in-order latency memory
// model and a scoreboard monitor comparing delivered words against mem[pc].
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] core_pc = RESET_PC;
    logic        core_halt = 1'b0;
    logic [31:0] inst_data;
    logic        inst_valid;
    logic        misalign_err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .core_pc(core_pc), .core_halt(core_halt),
        .inst_data(inst_data), .inst_valid(inst_valid), .misalign_err(misalign_err),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          last_due = 0;
    logic [31:0] pc = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    int          n_consumed = 0;
    int          seen_consumed = 0;
    int          n_accept = 0;
    int          n_valid_cycles = 0;
    int          first_valid_cyc = -1;
    int          rel_cyc = 0;
    bit          chk_reset = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          gnt_mode = 0;
    bit          rand_halt = 1'b0;

    // Memory contents: a fixed, address-unique scramble of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (chk_reset) begin
                chk("reset imem_req", 32'(imem_req), 32'd0);
                chk("reset inst_valid", 32'(inst_valid), 32'd0);
                chk("reset inst_data", inst_data, 32'h13);
                chk("reset imem_addr", imem_addr, RESET_PC);
            end
        end else begin
            chk("misalign_err", 32'(misalign_err), 32'(core_pc[1:0] != 2'b00));
            if (core_pc[1:0] != 2'b00) begin
                chk("misaligned inst_valid", 32'(inst_valid), 32'd0);
                chk("misaligned imem_req", 32'(imem_req), 32'd0);
            end
            if (!inst_valid) begin
                chk("idle inst_data", inst_data, 32'h13);
            end else begin
                n_valid_cycles++;
                if (first_valid_cyc < rel_cyc) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL inst_data: got %h, expected no valid word (cycle %0d)", inst_data, cyc);
                end else begin
                    chk("inst_data", inst_data, exp_q[0]);
                end
                if (!core_halt) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    n_consumed++;
                end
            end
            if (imem_req && imem_gnt) begin
                int d;
                chk("imem_addr", imem_addr, exp_fetch);
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(d);
                exp_fetch = exp_fetch + 32'd4;
                n_accept++;
            end
            chk("outstanding <= DEPTH", 32'(mem_addr_q.size() <= DEPTH), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        while (seen_consumed != n_consumed) begin
            seen_consumed++;
            pc = pc + 32'd4;
            exp_q.push_back(memfn(pc));
            core_pc = pc;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        case (gnt_mode)
            0:       imem_gnt = 1'b1;
            1:       imem_gnt = (cyc % 3) == 0;
            default: imem_gnt = 1'($urandom_range(0, 1));
        endcase
        if (rand_halt) core_halt = ($urandom_range(0, 4) == 0);
    endtask

    task automatic jump(input logic [31:0] target);
        pc = target;
        core_pc = target;
        exp_q.delete();
        exp_q.push_back(memfn(target));
        exp_fetch = target;
    endtask

    task automatic do_reset(input bit halt);
        rand_halt = 1'b0;
        rst = 1'b1;
        core_halt = halt;
        mem_addr_q.delete();
        mem_due_q.delete();
        step();
        chk_reset = 1'b1;
        step();
        step();
        chk_reset = 1'b0;
        rst = 1'b0;
        seen_consumed = n_consumed;
        rel_cyc = cyc;
        jump(RESET_PC);
        core_halt = halt;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int target;
        target = n_consumed + n;
        for (int i = 0; i < budget && n_consumed < target; i++) step();
        chk(name, 32'(n_consumed >= target), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int acc0;
        int v0;
        logic [31:0] t;

        // Startup latency and back-to-back streaming.
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        base = n_consumed;
        repeat (5) step();
        chk("first inst_valid cycle", 32'(first_valid_cyc - rel_cyc + 1), 32'd3);
        chk("words by cycle 5", 32'(n_consumed - base), 32'd3);
        run_until(10, 30, "steady streaming");

        // Credit limit while halted.
        do_reset(1'b1);
        acc0 = n_accept;
        repeat (12) step();
        #1;
        chk("credit accepts", 32'(n_accept - acc0), 32'd4);
        chk("credit imem_req", 32'(imem_req), 32'd0);
        core_halt = 1'b0;
        run_until(8, 40, "drain after halt");

        // Redirect with responses in flight.
        lat_min = 3; lat_max = 3;
        do_reset(1'b0);
        for (int i = 0; i < 30 && mem_addr_q.size() < 2; i++) step();
        chk("in-flight before jump", 32'(mem_addr_q.size() >= 2), 32'd1);
        jump(32'h0000_0100);
        run_until(6, 60, "deliver after in-flight redirect");

        // Jump while halted with a full buffer.
        lat_min = 1; lat_max = 2;
        do_reset(1'b1);
        repeat (12) step();
        base = n_consumed;
        jump(32'h0000_0040);
        v0 = n_valid_cycles;
        for (int i = 0; i < 30 && n_valid_cycles == v0; i++) step();
        chk("valid after halted jump", 32'(n_valid_cycles > v0), 32'd1);
        repeat (3) step();
        chk("no pop while halted", 32'(n_consumed - base), 32'd0);
        core_halt = 1'b0;
        run_until(5, 40, "resume after halted jump");

        // Misaligned PC, then an aligned redirect.
        acc0 = n_accept;
        core_pc = pc + 32'h102;
        repeat (3) step();
        chk("no requests while misaligned", 32'(n_accept - acc0), 32'd0);
        jump(pc + 32'h104);
        run_until(5, 40, "resume after misalign");

        // Address wrap at the top of memory.
        lat_min = 1; lat_max = 4;
        step();
        jump(32'hFFFF_FFF8);
        run_until(6, 60, "wrap around 2^32");

        // Back-pressure: grant 1 on / 2 off, random latency.
        do_reset(1'b0);
        gnt_mode = 1;
        base = n_consumed;
        run_until(150, 1500, "back-pressure streaming");

        // Random grant, halts and jumps.
        gnt_mode = 2;
        rand_halt = 1'b1;
        base = n_consumed;
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 99) < 3) begin
                t = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
                if (t == pc) t = t + 32'd4;
                jump(t);
            end
        end
        chk("random phase progress", 32'(n_consumed - base > 100), 32'd1);

        rand_halt = 1'b0;
        core_halt = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
